alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Front-end controller for the 32-bit ALU datapath. It accepts one operation request at a time through a valid/ready handshake and decodes the opcode to a one-hot ALU control line. It pulses the ALU start input, holds operands stable, and waits a per-class latency for the multi-cycle units (Booth multiplier, divider, shifters/rotators). It then captures the 64-bit ALU result into a Z register (z_hi/z_lo) and signals completion to the datapath control unit.

Parameters:
SIMPLE_LAT, 1, wait cycles for ADD/SUB/AND/OR/NEG/NOT/INC
MUL_LAT, 33, wait cycles for MUL
DIV_LAT, 34, wait cycles for DIV
SHIFT_LAT, 33, wait cycles for SHR/SHL/ROR/ROL
CNT_W, 6, width of the latency counter; must hold max(*_LAT)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op_valid  in  1  request present
op_ready  out  1  sequencer can accept a request (high only in IDLE)
op_code  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 AND, 9 OR, 10 NEG, 11 NOT, 12 INC, 13-15 illegal
op_a  in  32  operand A
op_b  in  32  operand B
abort  in  1  cancel the in-flight operation
alu_a  out  32  latched operand A to ALU
alu_b  out  32  latched operand B to ALU
alu_ctl  out  13  one-hot ALU select, bit index = op_code
alu_start  out  1  one-cycle start pulse to ALU
alu_c  in  64  ALU result
z_hi  out  32  captured result upper word
z_lo  out  32  captured result lower word
res_valid  out  1  one-cycle pulse: z_hi/z_lo newly updated
illegal  out  1  one-cycle pulse: illegal op_code rejected
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): FSM to IDLE; alu_a, alu_b, z_hi, z_lo, counter = 0; alu_ctl = 0; alu_start, res_valid, illegal = 0; op_ready = 1; busy = 0. An in-flight op is dropped and Z is not written.
- States: IDLE, START, WAIT, CAPTURE.
- IDLE: op_ready = 1.
  - On op_valid and a legal code: latch op_a/op_b/op_code, go to START.
  - On op_valid and code 13-15: pulse illegal next cycle, stay in IDLE, Z unchanged, no alu_start.
- START (1 cycle): alu_start = 1; alu_ctl one-hot for the latched op; counter loaded with LAT-1 for the op class; next state WAIT.
- WAIT: alu_ctl held; counter decrements each cycle; at counter == 0, go to CAPTURE. WAIT lasts exactly LAT cycles.
- CAPTURE (1 cycle): alu_ctl held.
  - z_lo <= alu_c[31:0].
  - z_hi <= alu_c[63:32] for MUL and DIV; z_hi <= 0 for all other ops.
  - Next state IDLE, with res_valid = 1 in that first IDLE cycle.
- alu_ctl is 0 in IDLE. alu_a/alu_b are stable from START through CAPTURE and retain their last values in IDLE.
- Timing: accept at edge T gives alu_start high in cycle T+1, CAPTURE at T+2+LAT, res_valid high and z valid at T+3+LAT. Default ADD → T+4, MUL → T+36, DIV → T+37.
- Back-to-back: op_ready is high in the res_valid cycle, so a new op may be accepted then. Throughput is one op per LAT+3 cycles.
- abort in START or WAIT: go to IDLE next cycle; alu_ctl = 0; no capture, no res_valid; Z retains its old value.
- abort in CAPTURE is ignored; the capture completes.
- abort in IDLE has no effect. If abort and op_valid are both high in IDLE, the op is accepted.
- op_valid while busy is ignored; op_ready = 0, so the requester must hold the request.
- res_valid and illegal are never high in the same cycle.

Test Plan:
- Reset, then ADD op_a=5, op_b=7 → alu_start pulse at T+1, res_valid at T+4, z_lo=12, z_hi=0.
- MUL op_a=0xFFFFFFFF (−1), op_b=3 → res_valid at T+36, {z_hi,z_lo}=0xFFFFFFFF_FFFFFFFD; op_ready low T+1..T+35.
- DIV 100/7 → res_valid at T+37, z_lo=14, z_hi=2; then SUB 3−5 accepted in the res_valid cycle → z_lo=0xFFFFFFFE, z_hi=0, 4 cycles later.
- MUL accepted, abort asserted in the 10th WAIT cycle → IDLE next cycle, no res_valid, Z unchanged from the previous result, alu_ctl=0.
- op_code=14 with op_valid → illegal pulse for 1 cycle, no alu_start, busy stays 0.
- reset asserted mid-DIV WAIT → all outputs 0 asynchronously; after release, ROL op_a=0x80000001, op_b=1 → z_lo=0x00000003 at T+36.

Source files
------------

// File: rtl/alu_sequencer.sv
// Front-end sequencer for the 32-bit ALU: accepts one op, starts the ALU, waits a
// per-class latency, captures the 64-bit result into Z and flags completion.
module alu_sequencer #(
  parameter int SIMPLE_LAT = 1,
  parameter int MUL_LAT    = 33,
  parameter int DIV_LAT    = 34,
  parameter int SHIFT_LAT  = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        abort,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [12:0] alu_ctl,
  output logic        alu_start,
  input  logic [63:0] alu_c,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        res_valid,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        z_hi_q, z_hi_d, z_lo_q, z_lo_d;
  logic               res_valid_q, res_valid_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   lat_m1;

  // Counter preload is LAT-1 so that WAIT spans exactly LAT cycles.
  always_comb begin
    case (op_q)
      4'd2:                   lat_m1 = CNT_W'(MUL_LAT - 1);
      4'd3:                   lat_m1 = CNT_W'(DIV_LAT - 1);
      4'd4, 4'd5, 4'd6, 4'd7: lat_m1 = CNT_W'(SHIFT_LAT - 1);
      default:                lat_m1 = CNT_W'(SIMPLE_LAT - 1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    z_hi_d      = z_hi_q;
    z_lo_d      = z_lo_q;
    res_valid_d = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (op_code <= 4'd12) begin
            a_d     = op_a;
            b_d     = op_b;
            op_d    = op_code;
            state_d = S_START;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_START: begin
        cnt_d   = lat_m1;
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_CAPTURE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CAPTURE: begin
        // Only MUL and DIV produce a meaningful upper word.
        z_lo_d      = alu_c[31:0];
        z_hi_d      = (op_q == 4'd2 || op_q == 4'd3) ? alu_c[63:32] : 32'd0;
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      z_hi_q      <= '0;
      z_lo_q      <= '0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      z_hi_q      <= z_hi_d;
      z_lo_q      <= z_lo_d;
      res_valid_q <= res_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign alu_start = (state_q == S_START);
  assign alu_ctl   = (state_q == S_IDLE) ? 13'd0 : (13'd1 << op_q);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign z_hi      = z_hi_q;
  assign z_lo      = z_lo_q;
  assign res_valid = res_valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; the bench plays the ALU by driving alu_c with
// hand-computed results and checks handshake timing and Z capture.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        abort;
  logic [31:0] alu_a, alu_b;
  logic [12:0] alu_ctl;
  logic        alu_start;
  logic [63:0] alu_c;
  logic [31:0] z_hi, z_lo;
  logic        res_valid, illegal, busy;

  int total = 0;
  int bad   = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .abort(abort),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_start(alu_start),
    .alu_c(alu_c), .z_hi(z_hi), .z_lo(z_lo), .res_valid(res_valid),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an op at a negedge; returns in cycle T+1 (START) after checking it.
  task automatic op_go(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] c);
    op_code  = code;
    op_a     = a;
    op_b     = b;
    alu_c    = c;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("start_pulse", {alu_start, busy, op_ready}, 3'b110);
    chk("start_ctl", alu_ctl, 13'd1 << code);
    chk("start_ops", {alu_a, alu_b}, {a, b});
  endtask

  // From cycle T+1, walk to the res_valid cycle T+3+lat and check Z there.
  task automatic op_wait(input int lat, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [3:0] code);
    for (int i = 0; i < lat + 1; i++) begin
      tick();
      chk("wait_flags", {res_valid, busy, op_ready, alu_start}, 4'b0100);
      chk("wait_ctl", alu_ctl, 13'd1 << code);
    end
    tick();
    chk("done_flags", {res_valid, busy, op_ready, illegal}, 4'b1010);
    chk("done_z", {z_hi, z_lo}, {hi, lo});
    chk("done_ctl", alu_ctl, 13'd0);
  endtask

  initial begin
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 4'd0;
    op_a     = '0;
    op_b     = '0;
    abort    = 1'b0;
    alu_c    = '0;
    tick();
    chk("rst_flags", {op_ready, busy, alu_start, res_valid, illegal}, 5'b10000);
    chk("rst_z", {z_hi, z_lo}, 64'd0);
    chk("rst_ctl", alu_ctl, 13'd0);
    reset = 1'b0;
    tick();

    // ADD 5+7, upper ALU word must be discarded
    op_go(4'd0, 32'd5, 32'd7, {32'hDEAD_BEEF, 32'd12});
    op_wait(1, 32'd0, 32'd12, 4'd0);
    tick();
    chk("rv_one_cycle", res_valid, 1'b0);

    // MUL -1 * 3
    op_go(4'd2, 32'hFFFF_FFFF, 32'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    op_wait(33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'd2);
    tick();

    // DIV 100/7, then SUB 3-5 accepted in the res_valid cycle
    op_go(4'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    op_wait(34, 32'd2, 32'd14, 4'd3);
    op_go(4'd1, 32'd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b2b_rv_drop", res_valid, 1'b0);
    op_wait(1, 32'd0, 32'hFFFF_FFFE, 4'd1);
    tick();

    // MUL aborted in its 10th WAIT cycle
    op_go(4'd2, 32'd9, 32'd9, {32'h1234_5678, 32'h9ABC_DEF0});
    for (int i = 0; i < 10; i++) tick();
    chk("pre_abort", {busy, alu_ctl}, {1'b1, 13'h0004});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy, op_ready, res_valid}, 3'b010);
    chk("abort_ctl", alu_ctl, 13'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("abort_quiet", {res_valid, busy, alu_start}, 3'b000);
    end
    chk("abort_z", {z_hi, z_lo}, {32'd0, 32'hFFFF_FFFE});

    // illegal op_code
    op_code  = 4'd14;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("illegal_pulse", {illegal, alu_start, busy, res_valid}, 4'b1000);
    tick();
    chk("illegal_drop", {illegal, busy}, 2'b00);
    chk("illegal_z", {z_hi, z_lo}, {32'd0, 32'hFFFF_FFFE});

    // abort with op_valid in IDLE accepts; abort during CAPTURE is ignored
    abort = 1'b1;
    op_go(4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, {32'hAAAA_AAAA, 32'h00F0_00F0});
    abort = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    chk("capture_ctl", alu_ctl, 13'h0100);
    tick();
    abort = 1'b0;
    chk("abort_capture", {res_valid, z_hi, z_lo}, {1'b1, 32'd0, 32'h00F0_00F0});
    tick();

    // reset mid-DIV WAIT clears everything asynchronously
    op_go(4'd3, 32'd50, 32'd3, {32'd2, 32'd16});
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_flags", {op_ready, busy, alu_start, res_valid, illegal}, 5'b10000);
    chk("async_rst_regs", {z_hi, z_lo, alu_a, alu_b}, 128'd0);
    chk("async_rst_ctl", alu_ctl, 13'd0);
    tick();
    reset = 1'b0;
    tick();

    // ROL 0x80000001 by 1
    op_go(4'd7, 32'h8000_0001, 32'd1, {32'hFFFF_0000, 32'h0000_0003});
    op_wait(33, 32'd0, 32'h0000_0003, 4'd7);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
